uart_cmd_bridge: RTL
====================

// Module: uart_cmd_bridge
// PURPOSE
// Bus initiator for the uart register block (DF00 data, DF01 status).
// - Polls the status register and reads each received byte.
// - Decodes host command frames and performs reads/writes on a target register port (VIC regs).
// - Replies to the host through the uart TX data register.
// Lets a PC drive the VIC over serial without a CPU.
// PARAMETERS
// UART_BASE    16'hDF00  uart base address; data = BASE+0, status = BASE+1
// TIMEOUT      20000     clk cycles allowed between bytes of one frame before abort
// ACK_BYTE     8'h06     reply to a completed write
// NAK_BYTE     8'h15     reply to an unknown opcode
// PORTS
// clk                input   1   system clock
// reset              input   1   synchronous, active-high reset
// bus_access_strobe  input   1   bus cycle qualifier; a transfer happens only when high
// a                  output  16  address to uart
// select             output  1   uart chip select
// r_w_n              output  1   1 = read, 0 = write
// d_out              output  8   write data to uart (uart d_in)
// d_in               input   8   read data from uart (uart d_out), combinational
// tgt_addr           output  16  target register address
// tgt_wdata          output  8   target write data
// tgt_we             output  1   one-cycle target write pulse
// tgt_re             output  1   one-cycle target read pulse
// tgt_rdata          input   8   target read data, valid the cycle after tgt_re
// busy               output  1   high while a frame is in progress
// BEHAVIOUR
// Reset values:
// - Outputs: select=0, r_w_n=1, a=0, d_out=0, tgt_*=0, busy=0.
// - State: POLL_RX, timeout counter cleared.
// - Reset mid-frame discards the partial frame.
// Bus cycle rules:
// - A bus cycle holds a/r_w_n/d_out stable with select=1 until a clk edge where bus_access_strobe=1.
// - Read data is captured from d_in on that edge.
// - select drops on the following cycle.
// - select is never high for more than one strobe cycle per access.
// Uart register semantics:
// - Status bit3 = receiver_full; status bit4 = tx ready (~tx_busy).
// - Reading data clears receiver_full.
// - Writing data starts transmission.
// Frames (first byte = opcode):
// - 'W' 8'h57: addr_lo, addr_hi, data -> target write -> reply ACK_BYTE.
// - 'R' 8'h52: addr_lo, addr_hi -> target read -> reply tgt_rdata.
// - Any other opcode -> reply NAK_BYTE; no target access.
// States:
// - POLL_RX: read status. bit3=1 -> RD_RX; else stay.
// - RD_RX: read data into the frame byte selected by byte index idx (0..3).
//   - idx=0 -> DECODE.
//   - idx>0 and frame incomplete -> POLL_RX.
//   - frame complete -> EXEC.
// - DECODE:
//   - 'W'/'R' -> POLL_RX with idx=1.
//   - otherwise reply=NAK -> POLL_TX.
// - EXEC:
//   - W: tgt_we=1 for one cycle, reply=ACK.
//   - R: tgt_re=1 for one cycle, capture tgt_rdata the next cycle as reply.
//   - Then -> POLL_TX.
// - POLL_TX: read status. bit4=1 -> WR_TX; else stay.
// - WR_TX: write reply to data register -> POLL_RX, idx=0.
// Target port:
// - tgt_addr = {addr_hi, addr_lo}.
// - tgt_wdata is held stable from the tgt_we cycle until the next frame.
// Timeout:
// - Counter runs while idx>0 in POLL_RX and resets on each byte read.
// - Reaching TIMEOUT -> idx=0, no reply, no target access.
// - Timeout never fires in POLL_TX.
// busy = (idx != 0) or state in {EXEC, POLL_TX, WR_TX}.
// bus_access_strobe held low stalls the FSM in its current bus cycle with outputs held; no transfer is lost.
// TESTING
// - Host sends 57 20 D0 0E -> exactly one tgt_we with tgt_addr=D020, tgt_wdata=0E; uart TX byte 06.
// - tgt_rdata model returns 3C at D021; host sends 52 21 D0 -> one tgt_re at D021; reply byte 3C.
// - Host sends 41 -> reply 15; no tgt_we/tgt_re pulse; next 57 frame executes normally.
// - Host sends 57 20 then idles > TIMEOUT (set TIMEOUT=2000) -> busy falls, no reply.
//   A following 57 18 D0 1B writes 1B to D018.
// - bus_access_strobe pulsed 1-in-4 during a W frame -> same result as the first scenario.
//   select is never high across two strobe edges.
// - Assert reset between addr_hi and data of a W frame -> outputs at reset values, no tgt_we.
//   The next full frame succeeds.

Source files
------------

// File: rtl/uart_cmd_bridge.sv
// Serial command bridge: polls a uart register block for host frames and runs
// the decoded reads/writes on a target register port, replying through uart TX.
module uart_cmd_bridge #(
  parameter logic [15:0] UART_BASE = 16'hDF00,
  parameter int unsigned TIMEOUT   = 20000,
  parameter logic [7:0]  ACK_BYTE  = 8'h06,
  parameter logic [7:0]  NAK_BYTE  = 8'h15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bus_access_strobe,
  output logic [15:0] a,
  output logic        select,
  output logic        r_w_n,
  output logic [7:0]  d_out,
  input  logic [7:0]  d_in,
  output logic [15:0] tgt_addr,
  output logic [7:0]  tgt_wdata,
  output logic        tgt_we,
  output logic        tgt_re,
  input  logic [7:0]  tgt_rdata,
  output logic        busy
);
  localparam logic [7:0]    OP_WRITE = 8'h57;
  localparam logic [7:0]    OP_READ  = 8'h52;
  localparam int unsigned   CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    POLL_RX, RD_RX, DECODE, EXEC, EXEC_CAP, POLL_TX, WR_TX
  } state_t;

  state_t        state, state_nx;
  logic          bus_gap, in_bus, xfer, tmo_fire, frame_done;
  logic [1:0]    idx;
  logic [7:0]    opcode, addr_lo, addr_hi, reply;
  logic [CW-1:0] tmo_cnt;

  // bus_gap forces select low for one cycle after every completed access
  always_comb begin
    in_bus     = (state == POLL_RX) || (state == RD_RX) ||
                 (state == POLL_TX) || (state == WR_TX);
    xfer       = in_bus && !bus_gap && bus_access_strobe;
    tmo_fire   = (state == POLL_RX) && (idx != 2'd0) && (tmo_cnt == TMO_LAST);
    frame_done = ((opcode == OP_WRITE) && (idx == 2'd3)) ||
                 ((opcode == OP_READ)  && (idx == 2'd2));
    tgt_addr   = {addr_hi, addr_lo};
    busy       = (idx != 2'd0) || (state == EXEC) || (state == EXEC_CAP) ||
                 (state == POLL_TX) || (state == WR_TX);
  end

  always_comb begin
    state_nx = state;
    select   = 1'b0;
    r_w_n    = 1'b1;
    a        = '0;
    d_out    = '0;
    tgt_we   = 1'b0;
    tgt_re   = 1'b0;
    if (in_bus && !bus_gap) begin
      select = 1'b1;
      a      = ((state == POLL_RX) || (state == POLL_TX)) ? UART_BASE + 16'd1 : UART_BASE;
      r_w_n  = (state != WR_TX);
      d_out  = (state == WR_TX) ? reply : '0;
    end
    case (state)
      POLL_RX:  if (xfer && d_in[3]) state_nx = RD_RX;
      RD_RX:
        if (xfer) begin
          if (idx == 2'd0)     state_nx = DECODE;
          else if (frame_done) state_nx = EXEC;
          else                 state_nx = POLL_RX;
        end
      DECODE:   state_nx = ((opcode == OP_WRITE) || (opcode == OP_READ)) ? POLL_RX : POLL_TX;
      EXEC: begin
        tgt_we   = (opcode == OP_WRITE);
        tgt_re   = (opcode == OP_READ);
        state_nx = (opcode == OP_READ) ? EXEC_CAP : POLL_TX;
      end
      EXEC_CAP: state_nx = POLL_TX;
      POLL_TX:  if (xfer && d_in[4]) state_nx = WR_TX;
      WR_TX:    if (xfer) state_nx = POLL_RX;
      default:  state_nx = POLL_RX;
    endcase
    if (tmo_fire) state_nx = POLL_RX;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= POLL_RX;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus_gap   <= 1'b1;
      idx       <= 2'd0;
      opcode    <= '0;
      addr_lo   <= '0;
      addr_hi   <= '0;
      tgt_wdata <= '0;
      reply     <= '0;
      tmo_cnt   <= '0;
    end else begin
      bus_gap <= xfer;
      if ((state == POLL_RX) && (idx != 2'd0) && !tmo_fire) tmo_cnt <= tmo_cnt + CW'(1);
      else                                                   tmo_cnt <= '0;
      if (tmo_fire) begin
        idx <= 2'd0;
      end else begin
        case (state)
          RD_RX:
            if (xfer) begin
              // the data byte lands directly in tgt_wdata so it is valid during the tgt_we cycle
              case (idx)
                2'd0:    opcode    <= d_in;
                2'd1:    addr_lo   <= d_in;
                2'd2:    addr_hi   <= d_in;
                default: tgt_wdata <= d_in;
              endcase
              if ((idx != 2'd0) && !frame_done) idx <= idx + 2'd1;
            end
          DECODE:
            if ((opcode == OP_WRITE) || (opcode == OP_READ)) idx <= 2'd1;
            else                                             reply <= NAK_BYTE;
          EXEC:     if (opcode == OP_WRITE) reply <= ACK_BYTE;
          EXEC_CAP: reply <= tgt_rdata;
          WR_TX:    if (xfer) idx <= 2'd0;
          default: ;
        endcase
      end
    end
  end
endmodule
